// File: rtl/pattern_delay_timer_pkg.sv
// Shared state encoding and default parameters for the pattern-triggered delay timer.
// Optional abort input is enabled by defining PDT_ABORT_EN (see pattern_delay_timer).
package pattern_delay_timer_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOAD   = 2'd1,
        COUNT  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam int         DEF_PAT_W       = 4;
    localparam logic [3:0] DEF_PATTERN     = 4'b1101;
    localparam int         DEF_DLY_W       = 4;
    localparam int         DEF_UNIT_CYCLES = 1000;

endpackage

// File: rtl/pattern_delay_timer_unit_prescaler.sv
// Free-running 0..UNIT_CYCLES-1 counter; tick is combinational on the wrap cycle.
// No backpressure: clr dominates en, counter restarts from 0 after clr.
module unit_prescaler #(
    parameter int UNIT_CYCLES = 1000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && !clr && w_wrap;

endmodule

// File: rtl/pattern_delay_timer.sv
// Serial start-pattern detector + delay loader; counts (d+1)*UNIT_CYCLES clocks then holds done until ack.
// Outputs registered from next state; optional abort input under PDT_ABORT_EN.
module pattern_delay_timer
    import pattern_delay_timer_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN     = DEF_PATTERN,
    parameter int               DLY_W       = DEF_DLY_W,
    parameter int               UNIT_CYCLES = DEF_UNIT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             ack,
`ifdef PDT_ABORT_EN
    input  logic             abort,
`endif
    output logic [DLY_W-1:0] count,
    output logic             counting,
    output logic             done
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam int               LC_W      = (DLY_W > 1) ? $clog2(DLY_W) : 1;
    localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(DLY_W - 1);

    state_t            r_state;
    state_t            w_next;
    logic [PAT_W-2:0]  r_window;
    logic [FILL_W-1:0] r_fill;
    logic [DLY_W-2:0]  r_delay;
    logic [LC_W-1:0]   r_load_cnt;
    logic [DLY_W-1:0]  r_count;
    logic              r_counting;
    logic              r_done;

    logic [PAT_W-1:0]  w_shift;
    logic [DLY_W-1:0]  w_delay_next;
    logic              w_match;
    logic              w_tick;
    logic              w_abort;
    logic              w_presc_clr;
    logic              w_presc_en;

`ifdef PDT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Fill counter blocks matches against the zeros left in the window by a clear.
    assign w_shift      = {r_window, data};
    assign w_match      = (r_fill == FILL_FULL) && (w_shift == PATTERN);
    assign w_delay_next = {r_delay, data};

    assign w_presc_en  = (r_state == COUNT);
    assign w_presc_clr = reset || (r_state != COUNT);

    unit_prescaler #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_prescaler (
        .clk  (clk),
        .clr  (w_presc_clr),
        .en   (w_presc_en),
        .tick (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            SEARCH: begin
                if (w_match) w_next = LOAD;
            end
            LOAD: begin
                if (w_abort)                       w_next = SEARCH;
                else if (r_load_cnt == LOAD_LAST)  w_next = COUNT;
            end
            COUNT: begin
                if (w_abort)                       w_next = SEARCH;
                else if (w_tick && r_count == '0)  w_next = WAIT;
            end
            WAIT: begin
                if (ack) w_next = SEARCH;
            end
            default: w_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_window   <= '0;
            r_fill     <= '0;
            r_delay    <= '0;
            r_load_cnt <= '0;
            r_count    <= '0;
            r_counting <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_counting <= (w_next == COUNT);
            r_done     <= (w_next == WAIT);

            // Window only survives while we stay in SEARCH; any exit or re-entry starts empty.
            if (r_state == SEARCH && w_next == SEARCH) begin
                r_window <= w_shift[PAT_W-2:0];
                if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
            end else begin
                r_window <= '0;
                r_fill   <= '0;
            end

            if (r_state == LOAD) begin
                r_delay    <= w_delay_next[DLY_W-2:0];
                r_load_cnt <= r_load_cnt + 1'b1;
            end else begin
                r_load_cnt <= '0;
            end

            // The WAIT transition is taken on the zero wrap, so count never underflows.
            if (w_next == COUNT) begin
                if (r_state == LOAD)  r_count <= w_delay_next;
                else if (w_tick)      r_count <= r_count - 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

    assign count    = r_count;
    assign counting = r_counting;
    assign done     = r_done;

endmodule
